// File: rtl/biquad_pkg.sv
// Shared types and constants for the biquad cascade sequencer: FSM states and coefficient slot layout.
package biquad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ARM,
      ST_WAIT,
      ST_OUT,
      ST_COMMIT
   } seq_state_t;

   localparam int unsigned NUM_COEFS = 5;

   localparam logic [2:0] COEF_B0 = 3'd0;
   localparam logic [2:0] COEF_B1 = 3'd1;
   localparam logic [2:0] COEF_B2 = 3'd2;
   localparam logic [2:0] COEF_A1 = 3'd3;
   localparam logic [2:0] COEF_A2 = 3'd4;

   // Flat slot of a (stage, index) pair in a stage-major coefficient array.
   function automatic int unsigned coef_slot(input logic [2:0] stage, input logic [2:0] index);
      return 32'(stage) * NUM_COEFS + 32'(index);
   endfunction

endpackage

// File: rtl/biquad_coef_shadow.sv
// Shadow coefficient bank: STAGES x NUM_COEFS registers, one synchronous write port and one
// combinational read port. Out-of-range writes are dropped; out-of-range reads return zero.
module biquad_coef_shadow
   import biquad_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned STAGES     = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [2:0]            wr_stage,
   input  logic [2:0]            wr_index,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [2:0]            rd_stage,
   input  logic [2:0]            rd_index,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int unsigned DEPTH = STAGES * NUM_COEFS;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_ok;
   logic                  rd_ok;
   logic [AW-1:0]         wr_slot;
   logic [AW-1:0]         rd_slot;

   always_comb begin
      wr_ok   = wr_en && (32'(wr_stage) < STAGES) && (32'(wr_index) < NUM_COEFS);
      rd_ok   = (32'(rd_stage) < STAGES) && (32'(rd_index) < NUM_COEFS);
      wr_slot = AW'(coef_slot(wr_stage, wr_index));
      rd_slot = AW'(coef_slot(rd_stage, rd_index));
      rd_data = rd_ok ? mem[rd_slot] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            mem[k] <= '0;
         end
      end else if (wr_ok) begin
         mem[wr_slot] <= wr_data;
      end
   end

endmodule

// File: rtl/biquad_cascade_sequencer.sv
// Drives a cascade of STAGES biquad units one sample at a time and commits a shadow coefficient bank
// between samples. Optional macro BIQUAD_SEQ_BYPASS_EN adds bypass_mask to skip individual stages.
module biquad_cascade_sequencer
   import biquad_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned STAGES     = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        sample_in,
   input  logic                         sample_in_valid,
   output logic                         sample_in_ready,
   output logic [DATA_WIDTH-1:0]        sample_out,
   output logic                         sample_out_valid,
   input  logic [DATA_WIDTH-1:0]        coef_data,
   input  logic [2:0]                   coef_stage,
   input  logic [2:0]                   coef_index,
   input  logic                         coef_write,
   input  logic                         coef_commit,
   output logic                         coef_busy,
   output logic                         error,
`ifdef BIQUAD_SEQ_BYPASS_EN
   input  logic [STAGES-1:0]            bypass_mask,
`endif
   output logic [DATA_WIDTH-1:0]        biq_sample_in,
   output logic [STAGES-1:0]            biq_start,
   input  logic [STAGES-1:0]            biq_ready,
   input  logic [STAGES*DATA_WIDTH-1:0] biq_sample_out,
   output logic [DATA_WIDTH-1:0]        biq_param_in,
   output logic [2:0]                   biq_param_target,
   output logic [STAGES-1:0]            biq_write_param
);

   localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [2:0]  LAST_STAGE = 3'(STAGES - 1);
   localparam logic [2:0]  LAST_COEF  = 3'(NUM_COEFS - 1);

   seq_state_t            state, state_nxt;
   logic [2:0]            stage, stage_nxt;
   logic [DATA_WIDTH-1:0] cur, cur_nxt;
   logic [TW-1:0]         timer, timer_nxt;
   logic                  commit_pending, pending_nxt;
   logic                  error_nxt;
   logic [2:0]            cs, cs_nxt;
   logic [2:0]            ci, ci_nxt;
   logic                  run;
   logic                  load_out;
   logic                  sel_ready;
   logic                  sel_skip;
   logic [DATA_WIDTH-1:0] sel_out;
   logic [DATA_WIDTH-1:0] shadow_rd;

   biquad_coef_shadow #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (STAGES)
   ) u_shadow (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (coef_write),
      .wr_stage (coef_stage),
      .wr_index (coef_index),
      .wr_data  (coef_data),
      .rd_stage (cs),
      .rd_index (ci),
      .rd_data  (shadow_rd)
   );

   always_comb begin
      sel_ready = 1'b0;
      sel_skip  = 1'b0;
      sel_out   = '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
         if (stage == 3'(s)) begin
            sel_ready = biq_ready[s];
            sel_out   = biq_sample_out[s*DATA_WIDTH +: DATA_WIDTH];
`ifdef BIQUAD_SEQ_BYPASS_EN
            sel_skip  = bypass_mask[s];
`endif
         end
      end
   end

   assign coef_busy = commit_pending | (state == ST_COMMIT);

   always_comb begin
      state_nxt        = state;
      stage_nxt        = stage;
      cur_nxt          = cur;
      timer_nxt        = timer;
      error_nxt        = error;
      cs_nxt           = cs;
      ci_nxt           = ci;
      pending_nxt      = commit_pending | coef_commit;
      load_out         = 1'b0;
      sample_in_ready  = 1'b0;
      sample_out_valid = 1'b0;
      biq_sample_in    = '0;
      biq_start        = '0;
      biq_param_in     = '0;
      biq_param_target = '0;
      biq_write_param  = '0;

      case (state)
         ST_IDLE: begin
            // A commit requested this very cycle also blocks the sample, so ready must see it too.
            sample_in_ready = run & ~commit_pending & ~coef_commit;
            if (commit_pending | coef_commit) begin
               state_nxt   = ST_COMMIT;
               pending_nxt = 1'b0;
               cs_nxt      = '0;
               ci_nxt      = '0;
            end else if (sample_in_valid && sample_in_ready) begin
               cur_nxt   = sample_in;
               stage_nxt = '0;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            biq_sample_in = cur;
            if (sel_skip) begin
               if (stage == LAST_STAGE) begin
                  state_nxt = ST_OUT;
                  load_out  = 1'b1;
               end else begin
                  stage_nxt = stage + 3'd1;
               end
            end else begin
               for (int unsigned s = 0; s < STAGES; s++) begin
                  if (stage == 3'(s)) biq_start[s] = 1'b1;
               end
               state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            timer_nxt = '0;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (sel_ready || (timer == TW'(TIMEOUT))) begin
               if (sel_ready) cur_nxt = sel_out;
               else           error_nxt = 1'b1;
               if (stage == LAST_STAGE) begin
                  state_nxt = ST_OUT;
                  load_out  = 1'b1;
               end else begin
                  stage_nxt = stage + 3'd1;
                  state_nxt = ST_START;
               end
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         ST_OUT: begin
            sample_out_valid = 1'b1;
            state_nxt        = ST_IDLE;
         end
         ST_COMMIT: begin
            biq_param_in     = shadow_rd;
            biq_param_target = ci;
            for (int unsigned s = 0; s < STAGES; s++) begin
               if (cs == 3'(s)) biq_write_param[s] = 1'b1;
            end
            if (ci == LAST_COEF) begin
               ci_nxt = '0;
               if (cs == LAST_STAGE) begin
                  cs_nxt    = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  cs_nxt = cs + 3'd1;
               end
            end else begin
               ci_nxt = ci + 3'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // sample_out is loaded on the transition into OUT so it is valid alongside the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         stage          <= '0;
         cur            <= '0;
         timer          <= '0;
         commit_pending <= 1'b0;
         error          <= 1'b0;
         cs             <= '0;
         ci             <= '0;
         run            <= 1'b0;
         sample_out     <= '0;
      end else begin
         state          <= state_nxt;
         stage          <= stage_nxt;
         cur            <= cur_nxt;
         timer          <= timer_nxt;
         commit_pending <= pending_nxt;
         error          <= error_nxt;
         cs             <= cs_nxt;
         ci             <= ci_nxt;
         run            <= 1'b1;
         if (load_out) sample_out <= cur_nxt;
      end
   end

endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Self-checking bench for biquad_cascade_sequencer with two behavioural filter units and a reference model.
// Define BIQUAD_SEQ_BYPASS_EN for both bench and RTL to exercise the bypass path.
module tb_biquad_cascade_sequencer;

   localparam int DW = 16;
   localparam int ST = 2;
   localparam int TO = 255;

   logic            clk = 1'b0;
   logic            reset;
   logic [DW-1:0]   sample_in;
   logic            sample_in_valid;
   logic            sample_in_ready;
   logic [DW-1:0]   sample_out;
   logic            sample_out_valid;
   logic [DW-1:0]   coef_data;
   logic [2:0]      coef_stage;
   logic [2:0]      coef_index;
   logic            coef_write;
   logic            coef_commit;
   logic            coef_busy;
   logic            error;
   logic [DW-1:0]   biq_sample_in;
   logic [ST-1:0]   biq_start;
   logic [ST-1:0]   biq_ready;
   logic [ST*DW-1:0] biq_sample_out;
   logic [DW-1:0]   biq_param_in;
   logic [2:0]      biq_param_target;
   logic [ST-1:0]   biq_write_param;
`ifdef BIQUAD_SEQ_BYPASS_EN
   logic [ST-1:0]   bypass_mask;
`endif

   biquad_cascade_sequencer #(
      .DATA_WIDTH (DW),
      .STAGES     (ST),
      .TIMEOUT    (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_in_ready  (sample_in_ready),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .coef_data        (coef_data),
      .coef_stage       (coef_stage),
      .coef_index       (coef_index),
      .coef_write       (coef_write),
      .coef_commit      (coef_commit),
      .coef_busy        (coef_busy),
      .error            (error),
`ifdef BIQUAD_SEQ_BYPASS_EN
      .bypass_mask      (bypass_mask),
`endif
      .biq_sample_in    (biq_sample_in),
      .biq_start        (biq_start),
      .biq_ready        (biq_ready),
      .biq_sample_out   (biq_sample_out),
      .biq_param_in     (biq_param_in),
      .biq_param_target (biq_param_target),
      .biq_write_param  (biq_write_param)
   );

   always #5 clk = ~clk;

   // Test units use a memoryless weighted transfer so every coefficient slot affects the output.
   function automatic logic [DW-1:0] unit_f(input logic [DW-1:0] b0, b1, b2, a1, a2, x);
      int acc;
      acc = (int'($signed(b0)) * int'($signed(x))) >>> 15;
      acc = acc + int'($signed(b1)) + 2 * int'($signed(b2)) - 3 * int'($signed(a1)) - 5 * int'($signed(a2));
      return acc[DW-1:0];
   endfunction

   logic [DW-1:0] ucoef [ST][5];
   logic [DW-1:0] ux [ST];
   logic [DW-1:0] uy [ST];
   int            ucnt [ST];
   int            ulat;
   logic [ST-1:0] hold;

   always @(posedge clk) begin
      for (int s = 0; s < ST; s++) begin
         if (biq_write_param[s] && biq_param_target < 3'd5) ucoef[s][biq_param_target] <= biq_param_in;
         if (reset) begin
            ucnt[s] <= 0;
         end else if (biq_start[s]) begin
            ux[s]   <= biq_sample_in;
            ucnt[s] <= ulat;
         end else if (ucnt[s] > 0) begin
            ucnt[s] <= ucnt[s] - 1;
            if (ucnt[s] == 1) uy[s] <= unit_f(ucoef[s][0], ucoef[s][1], ucoef[s][2], ucoef[s][3], ucoef[s][4], ux[s]);
         end
      end
   end

   assign biq_ready      = {(ucnt[1] == 0) && !hold[1], (ucnt[0] == 0) && !hold[0]};
   assign biq_sample_out = {uy[1], uy[0]};

   logic [31:0] wq [$];
   logic [DW-1:0] oq [$];
   int nstart;

   always @(negedge clk) begin
      if (biq_write_param != '0) wq.push_back({6'b0, biq_write_param, 5'b0, biq_param_target, biq_param_in});
      for (int s = 0; s < ST; s++) if (biq_start[s]) nstart++;
      if (sample_out_valid) oq.push_back(sample_out);
   end

   logic [DW-1:0] shadow_m [ST][5];
   logic [DW-1:0] active_m [ST][5];

   function automatic logic [DW-1:0] ref_through(input logic [DW-1:0] x, input int n);
      logic [DW-1:0] y;
      y = x;
      for (int s = 0; s < n; s++)
         y = unit_f(active_m[s][0], active_m[s][1], active_m[s][2], active_m[s][3], active_m[s][4], y);
      return y;
   endfunction

   int total = 0;
   int bad   = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wcoef(input int s, input int i, input logic [DW-1:0] d);
      coef_stage = 3'(s);
      coef_index = 3'(i);
      coef_data  = d;
      coef_write = 1'b1;
      tick();
      coef_write = 1'b0;
      if (s < ST && i < 5) shadow_m[s][i] = d;
   endtask

   task automatic chk_strobes(input string tag);
      logic [31:0] got;
      chk({tag, "_nwr"}, wq.size(), 32'd10);
      for (int s = 0; s < ST; s++) begin
         for (int i = 0; i < 5; i++) begin
            got = (wq.size() > 0) ? wq.pop_front() : 'x;
            chk({tag, "_wr"}, got, {6'b0, 2'(1 << s), 5'b0, 3'(i), shadow_m[s][i]});
         end
      end
      wq.delete();
   endtask

   task automatic commit_wait(input string tag);
      int n;
      wq.delete();
      coef_commit = 1'b1;
      tick();
      coef_commit = 1'b0;
      n = 0;
      while (coef_busy && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_busy"}, coef_busy, 1'b0);
      chk_strobes(tag);
      for (int s = 0; s < ST; s++) for (int i = 0; i < 5; i++) active_m[s][i] = shadow_m[s][i];
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!sample_in_ready && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_ready"}, sample_in_ready, 1'b1);
   endtask

   task automatic send(input string tag, input logic [DW-1:0] x);
      sample_in       = x;
      sample_in_valid = 1'b1;
      wait_ready(tag);
      tick();
      sample_in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [DW-1:0] exp);
      int n;
      logic [DW-1:0] got;
      n = 0;
      while (oq.size() == 0 && n < 2000) begin
         tick();
         n++;
      end
      got = (oq.size() > 0) ? oq.pop_front() : 'x;
      chk(tag, got, exp);
      tick();
      tick();
      chk({tag, "_single"}, oq.size(), 0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ready"}, sample_in_ready, 1'b0);
      chk({tag, "_sout"}, sample_out, '0);
      chk({tag, "_svalid"}, sample_out_valid, 1'b0);
      chk({tag, "_busy"}, coef_busy, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_start"}, biq_start, '0);
      chk({tag, "_wparam"}, biq_write_param, '0);
      chk({tag, "_bsin"}, biq_sample_in, '0);
      chk({tag, "_pin"}, biq_param_in, '0);
      chk({tag, "_ptgt"}, biq_param_target, 3'd0);
   endtask

   initial begin
      logic [DW-1:0] x;
      reset = 1'b1;
      sample_in = '0; sample_in_valid = 1'b0;
      coef_data = '0; coef_stage = '0; coef_index = '0; coef_write = 1'b0; coef_commit = 1'b0;
      hold = '0; ulat = 3; nstart = 0;
`ifdef BIQUAD_SEQ_BYPASS_EN
      bypass_mask = '0;
`endif
      for (int s = 0; s < ST; s++) for (int i = 0; i < 5; i++) begin
         shadow_m[s][i] = '0;
         active_m[s][i] = '0;
      end

      tick();
      chk_idle_outputs("rst");
      tick();
      reset = 1'b0;
      tick();

      // Half-gain in both stages: 0x1000 -> 0x0800 -> 0x0400.
      wcoef(0, 0, 16'h4000);
      wcoef(1, 0, 16'h4000);
      commit_wait("spec_c");
      send("spec", 16'h1000);
      expect_out("spec_out", 16'h0400);
      chk("spec_err", error, 1'b0);

      // Commit and sample offered together: commit first, sample after.
      for (int s = 0; s < ST; s++) for (int i = 0; i < 5; i++) wcoef(s, i, 16'($urandom_range(0, 16'h3FFF)));
      wq.delete();
      x = 16'($urandom);
      sample_in = x;
      sample_in_valid = 1'b1;
      coef_commit = 1'b1;
      #1;
      chk("cc_blocked", sample_in_ready, 1'b0);
      tick();
      coef_commit = 1'b0;
      wait_ready("cc");
      chk_strobes("cc");
      for (int s = 0; s < ST; s++) for (int i = 0; i < 5; i++) active_m[s][i] = shadow_m[s][i];
      tick();
      sample_in_valid = 1'b0;
      expect_out("cc_out", ref_through(x, ST));

      // Random coefficient sets, including out-of-range targets, and random unit latencies.
      for (int it = 0; it < 4; it++) begin
         for (int w = 0; w < 6; w++) wcoef($urandom_range(0, 3), $urandom_range(0, 7), 16'($urandom));
         commit_wait("rnd_c");
         for (int k = 0; k < 3; k++) begin
            ulat = $urandom_range(1, 5);
            x = 16'($urandom);
            send("rnd", x);
            expect_out("rnd_out", ref_through(x, ST));
         end
      end

      // Shadow writes while a sample is in flight must not reach the units.
      ulat = 6;
      x = 16'($urandom);
      send("wt", x);
      tick();
      tick();
      wq.delete();
      wcoef(0, 0, 16'($urandom));
      wcoef(1, 3, 16'($urandom));
      expect_out("wt_out", ref_through(x, ST));
      chk("wt_nowr", wq.size(), 0);
      x = 16'($urandom);
      send("wt2", x);
      expect_out("wt2_out", ref_through(x, ST));

      // Stage 1 never ready: timeout, pass-through of stage-0 result, sticky error.
      ulat = 2;
      hold = 2'b10;
      x = 16'($urandom);
      send("to", x);
      expect_out("to_out", ref_through(x, 1));
      chk("to_err", error, 1'b1);
      chk("to_idle", sample_in_ready, 1'b1);
      hold = '0;
      x = 16'($urandom);
      send("to2", x);
      expect_out("to2_out", ref_through(x, ST));
      chk("to_sticky", error, 1'b1);

      // Reset while waiting on a unit: sample dropped, everything back to reset values.
      ulat = 20;
      send("rw", 16'($urandom));
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk_idle_outputs("rw");
      tick();
      reset = 1'b0;
      ulat = 2;
      for (int s = 0; s < ST; s++) for (int i = 0; i < 5; i++) shadow_m[s][i] = '0;
      tick();
      tick();
      tick();
      chk("rw_noout", oq.size(), 0);
      x = 16'($urandom);
      send("rw2", x);
      expect_out("rw2_out", ref_through(x, ST));
      chk("rw2_err", error, 1'b0);

`ifdef BIQUAD_SEQ_BYPASS_EN
      bypass_mask = '1;
      nstart = 0;
      send("byp", 16'h7FFF);
      expect_out("byp_out", 16'h7FFF);
      chk("byp_nostart", nstart, 0);
      bypass_mask = '0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
